adder_32: RTL and testbench



---
 rtl/adder_pkg.sv | 8 +
 rtl/adder_32_if.sv | 14 +
 rtl/adder_32_cla4.sv | 33 +++
 rtl/adder_32.sv | 68 ++++++
 tb/tb_adder_32.sv | 123 ++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the registered 32-bit carry-lookahead adder.
package adder_pkg;

  localparam int ADDER_W  = 32;
  localparam int SLICE_W  = 4;
  localparam int N_SLICES = ADDER_W / SLICE_W;

endpackage

// File: rtl/adder_32_if.sv
// Operand/result bundle between the datapath and the registered adder.
interface adder_32_if;
  import adder_pkg::*;

  logic [ADDER_W-1:0] d0;
  logic [ADDER_W-1:0] d1;
  logic [ADDER_W-1:0] out;
  logic               cout;
  logic               ovf;

  modport master (output d0, output d1, input out, input cout, input ovf);
  modport slave  (input d0, input d1, output out, output cout, output ovf);

endinterface

// File: rtl/adder_32_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group generate/propagate.
module cla4
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               g,
  output logic               p
);

  logic [SLICE_W-1:0] gen;
  logic [SLICE_W-1:0] prop;
  logic [SLICE_W-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Every internal carry is a flat sum of products of cin, gen and prop.
  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign s = prop ^ c;

  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p = &prop;

endmodule

// File: rtl/adder_32.sv
// Registered 32-bit adder (PC+4 / branch target) with carry-out and signed overflow.
module adder_32
  import adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  adder_32_if.slave  bus
);

  logic [N_SLICES-1:0] grp_g;
  logic [N_SLICES-1:0] grp_p;
  logic [N_SLICES:0]   carry;
  logic [ADDER_W-1:0]  sum;
  logic                ovf_comb;

  logic [ADDER_W-1:0]  sum_p0;
  logic                cout_p0;
  logic                ovf_p0;

  for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
    cla4 u_cla4 (
      .a   (bus.d0[k*SLICE_W +: SLICE_W]),
      .b   (bus.d1[k*SLICE_W +: SLICE_W]),
      .cin (carry[k]),
      .s   (sum[k*SLICE_W +: SLICE_W]),
      .g   (grp_g[k]),
      .p   (grp_p[k])
    );
  end

  // Second-level lookahead: each slice carry is expanded from all lower G/P
  // terms directly, so no carry ever ripples slice to slice. Carry-in is 0.
  always_comb begin
    logic term;
    carry = '0;
    term  = 1'b0;
    for (int k = 1; k <= N_SLICES; k++) begin
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        carry[k] = carry[k] | term;
      end
    end
  end

  assign ovf_comb = (bus.d0[ADDER_W-1] == bus.d1[ADDER_W-1])
                 && (sum[ADDER_W-1] != bus.d0[ADDER_W-1]);

  // Stage p0: single output register, all flags updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p0  <= '0;
      cout_p0 <= 1'b0;
      ovf_p0  <= 1'b0;
    end else begin
      sum_p0  <= sum;
      cout_p0 <= carry[N_SLICES];
      ovf_p0  <= ovf_comb;
    end
  end

  assign bus.out  = sum_p0;
  assign bus.cout = cout_p0;
  assign bus.ovf  = ovf_p0;

endmodule

// File: tb/tb_adder_32.sv
// Directed and random checks of the registered 32-bit adder.
module tb_adder_32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  adder_32_if bus ();

  adder_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.d0 = a;
    bus.d1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_out,
                         input logic e_cout, input logic e_ovf);
    chk({tag, "_out"},  {2'b00, bus.out},  {2'b00, e_out});
    chk({tag, "_cout"}, {33'd0, bus.cout}, {33'd0, e_cout});
    chk({tag, "_ovf"},  {33'd0, bus.ovf},  {33'd0, e_ovf});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] ref_sum;
    logic        ref_ovf;
    total = 0;
    bad   = 0;

    // Reset held with all-ones operands while the clock runs
    rst_n  = 1'b0;
    bus.d0 = 32'hFFFF_FFFF;
    bus.d1 = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_edge", 32'hFFFF_FFFE, 1'b1, 1'b0);

    step(32'hFFFF_FFFF, 32'h0000_0000);
    chk_all("ones_plus_zero", 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(32'h00FF_FFFF, 32'hFFFF_FFFF);
    chk_all("low24_plus_ones", 32'h00FF_FFFE, 1'b1, 1'b0);
    step(32'h00FF_FFFF, 32'h0000_0001);
    chk_all("carry24", 32'h0100_0000, 1'b0, 1'b0);
    step(32'hFFFF_FF00, 32'h0000_0100);
    chk_all("carry_out_wrap", 32'h0000_0000, 1'b1, 1'b0);
    step(32'h7FFF_FFFF, 32'h0000_0001);
    chk_all("pos_ovf", 32'h8000_0000, 1'b0, 1'b1);
    step(32'h8000_0000, 32'h8000_0000);
    chk_all("neg_ovf", 32'h0000_0000, 1'b1, 1'b1);
    step(32'h0000_0001, 32'h7FFF_FFFF);
    chk_all("pos_ovf_swapped", 32'h8000_0000, 1'b0, 1'b1);

    // Operand changes between edges must not reach the outputs
    step(32'h0000_0001, 32'h0000_0002);
    chk_all("hold_base", 32'h0000_0003, 1'b0, 1'b0);
    bus.d0 = 32'h0000_0005;
    bus.d1 = 32'h0000_0006;
    #2;
    chk_all("hold_mid", 32'h0000_0003, 1'b0, 1'b0);
    @(negedge clk);
    bus.d0 = 32'h0000_0007;
    bus.d1 = 32'h0000_0008;
    #1;
    chk_all("hold_neg", 32'h0000_0003, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("hold_next_edge", 32'h0000_000F, 1'b0, 1'b0);

    // Asynchronous reset between edges clears outputs at once
    step(32'hFFFF_FFFF, 32'h8000_0000);
    chk_all("pre_async", 32'h7FFF_FFFF, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_clear", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h0040_0000, 32'h0000_0004);
    chk_all("after_async", 32'h0040_0004, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) b = ~a + 32'(i % 3);
      ref_sum = {1'b0, a} + {1'b0, b};
      ref_ovf = (a[31] == b[31]) && (ref_sum[31] != a[31]);
      step(a, b);
      chk("random", {ref_sum[32] ^ 1'b0, ref_ovf, ref_sum[31:0]} ^ 34'd0 ^
          {bus.cout, bus.ovf, bus.out} ^ {ref_sum[32], ref_ovf, ref_sum[31:0]},
          {ref_sum[32], ref_ovf, ref_sum[31:0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
